// File: rtl/aer_rate_encoder_feeder.sv
// aer_rate_encoder_feeder: rate-codes pixel RAM samples into 4-phase AER spike events
// Reads one 8-bit pixel per input neuron, compares it with a 16-bit Galois LFSR each
// time step and emits a spike event when the pixel wins; a marker event closes every
// step. After the last step it waits for the core's process-done, then pulses done.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_start, i_seed       start pulse (ignored while busy) and LFSR seed (0 -> 16'hACE1)
//   o_pix_rd_en/o_pix_addr/i_pix_data  pixel RAM port, data valid one cycle after read
//   o_aerin_addr/o_aerin_req/i_aerin_ack  4-phase AER event handshake towards the core
//   i_process_done        core finished the sample (only honoured while waiting for it)
//   o_busy, o_sample_done, o_event_cnt  status, one-cycle done pulse, saturating spike count
module aer_rate_encoder_feeder #(
   parameter int                   TIME_STEP      = 8,
   parameter int                   INPUT_NEURON   = 784,
   parameter int                   AER_WIDTH      = 12,
   parameter int                   PIX_ADDR_WIDTH = 10,
   parameter logic [AER_WIDTH-1:0] STEP_MARKER    = 12'hFFF
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic [15:0]               i_seed,
   output logic                      o_pix_rd_en,
   output logic [PIX_ADDR_WIDTH-1:0] o_pix_addr,
   input  logic [7:0]                i_pix_data,
   output logic [AER_WIDTH-1:0]      o_aerin_addr,
   output logic                      o_aerin_req,
   input  logic                      i_aerin_ack,
   input  logic                      i_process_done,
   output logic                      o_busy,
   output logic                      o_sample_done,
   output logic [15:0]               o_event_cnt
);
   localparam int          TW        = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   typedef enum logic [3:0] {
      S_IDLE, S_READ, S_CMP, S_REQ, S_ACK_HI, S_ACK_LO, S_NEXT, S_WAIT_DONE, S_DONE
   } state_t;

   state_t                    r_state, w_next;
   logic [PIX_ADDR_WIDTH-1:0] r_pix;
   logic [TW-1:0]             r_t;
   logic [15:0]               r_lfsr, r_cnt, w_lfsr_nxt;
   logic [AER_WIDTH-1:0]      r_addr;
   logic                      r_req, r_marker;
   logic                      w_spike, w_last_pix, w_last_step;

   // pixel 0 can never spike because the compare is strict
   assign w_spike     = i_pix_data > r_lfsr[7:0];
   assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_last_pix  = r_pix == PIX_ADDR_WIDTH'(INPUT_NEURON - 1);
   assign w_last_step = r_t == TW'(TIME_STEP - 1);

   assign o_pix_addr   = r_pix;
   assign o_aerin_addr = r_addr;
   assign o_aerin_req  = r_req;
   assign o_event_cnt  = r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (i_start) w_next = S_READ;
         S_READ:      w_next = S_CMP;
         S_CMP:       w_next = w_spike ? S_REQ : S_NEXT;
         // REQ is held off while the core still shows ACK from an earlier event
         S_REQ:       if (!i_aerin_ack) w_next = S_ACK_HI;
         S_ACK_HI:    if (i_aerin_ack) w_next = S_ACK_LO;
         S_ACK_LO:    if (!i_aerin_ack) w_next = !r_marker ? S_NEXT : w_last_step ? S_WAIT_DONE : S_READ;
         S_NEXT:      w_next = w_last_pix ? S_REQ : S_READ;
         S_WAIT_DONE: if (i_process_done) w_next = S_DONE;
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_pix_rd_en   = r_state == S_READ;
      o_busy        = r_state != S_IDLE;
      o_sample_done = r_state == S_DONE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pix    <= '0;
         r_t      <= '0;
         r_lfsr   <= LFSR_INIT;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_req    <= 1'b0;
         r_marker <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_pix    <= '0;
               r_t      <= '0;
               r_cnt    <= '0;
               r_marker <= 1'b0;
               r_lfsr   <= (i_seed == 16'h0000) ? LFSR_INIT : i_seed;
            end
            S_CMP: begin
               r_lfsr <= w_lfsr_nxt;
               if (w_spike) begin
                  r_addr   <= AER_WIDTH'(r_pix);
                  r_marker <= 1'b0;
               end
            end
            S_REQ:    if (!i_aerin_ack) r_req <= 1'b1;
            S_ACK_HI: if (i_aerin_ack) r_req <= 1'b0;
            S_ACK_LO: if (!i_aerin_ack) begin
               if (r_marker) begin
                  if (!w_last_step) begin
                     r_t   <= r_t + 1'b1;
                     r_pix <= '0;
                  end
               end else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 1'b1;
            end
            S_NEXT: begin
               if (w_last_pix) begin
                  r_addr   <= STEP_MARKER;
                  r_marker <= 1'b1;
               end else r_pix <= r_pix + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aer_rate_encoder_feeder.sv
// tb_aer_rate_encoder_feeder: randomized self-checking bench against a spike-list model
module tb_aer_rate_encoder_feeder;
   localparam int NN = 4;
   localparam int TS = 2;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ack = 1'b0, process_done = 1'b0;
   logic [15:0] seed_in = 16'h0;
   logic [7:0]  pix_data = 8'h0;
   logic        pix_rd_en, req, busy, sdone;
   logic [9:0]  pix_addr;
   logic [11:0] aer_addr;
   logic [15:0] ev_cnt;
   logic [7:0]  mem [0:NN-1];

   int          n_cmp = 0, n_err = 0;
   logic [11:0] got_ev[$], exp_ev[$];
   logic [15:0] exp_cnt;
   int          ack_lat = 0, wait_cnt = 0, markers = 0, pd_timer = 0, n_done = 0;
   int          run_len = 0, max_run = 0;
   logic        prev_req = 1'b0;
   logic [11:0] prev_addr = 12'h0;

   aer_rate_encoder_feeder #(
      .TIME_STEP(TS), .INPUT_NEURON(NN), .AER_WIDTH(12), .PIX_ADDR_WIDTH(10), .STEP_MARKER(12'hFFF)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_seed(seed_in),
      .o_pix_rd_en(pix_rd_en), .o_pix_addr(pix_addr), .i_pix_data(pix_data),
      .o_aerin_addr(aer_addr), .o_aerin_req(req), .i_aerin_ack(ack),
      .i_process_done(process_done), .o_busy(busy), .o_sample_done(sdone), .o_event_cnt(ev_cnt)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) if (pix_rd_en) pix_data <= mem[pix_addr[1:0]];

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   // every step visits all pixels in order; a pixel spikes when it beats the low LFSR byte
   function automatic void model(input logic [15:0] seed);
      logic [15:0] l;
      l = (seed == 16'h0) ? 16'hACE1 : seed;
      exp_ev.delete();
      exp_cnt = 16'h0;
      for (int t = 0; t < TS; t++) begin
         for (int p = 0; p < NN; p++) begin
            if (mem[p] > l[7:0]) begin
               exp_ev.push_back(12'(p));
               exp_cnt++;
            end
            l = lfsr_step(l);
         end
         exp_ev.push_back(12'hFFF);
      end
   endfunction

   // one clock: protocol monitor, then core-side responder (ACK and PROCESS_DONE)
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (req && !prev_req) begin
            n_cmp++;
            if (ack !== 1'b0) begin n_err++; $display("FAIL req_rise_under_ack: ack %b want 0", ack); end
         end
         if (aer_addr !== prev_addr) begin
            n_cmp++;
            if (prev_req || ack) begin
               n_err++;
               $display("FAIL addr_change_in_handshake: got %h was %h (req %b ack %b)", aer_addr, prev_addr, prev_req, ack);
            end
         end
         if (sdone) begin
            n_done++;
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL busy_at_done: got %b want 1", busy); end
         end
      end
      run_len = (req && !ack) ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      process_done = 1'b0;
      if (pd_timer > 0) begin
         pd_timer--;
         if (pd_timer == 0) process_done = 1'b1;
      end
      if (req && !ack) begin
         if (wait_cnt >= ack_lat) begin
            ack = 1'b1;
            wait_cnt = 0;
            got_ev.push_back(aer_addr);
            if (aer_addr == 12'hFFF) begin
               markers++;
               if (markers == TS) pd_timer = 3;
            end
         end else wait_cnt++;
      end else if (!req && ack) ack = 1'b0;
      prev_req = req;
      prev_addr = aer_addr;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      ack = 1'b0;
      wait_cnt = 0;
      pd_timer = 0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic run_sample(input logic [15:0] seed, input int lat, input int restart_at, input int pd_at, input string name);
      int cyc;
      cyc = 0;
      model(seed);
      got_ev.delete();
      markers = 0;
      n_done = 0;
      max_run = 0;
      ack_lat = lat;
      seed_in = seed;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
      while (n_done == 0 && cyc < 4000) begin
         if (cyc == restart_at) begin start = 1'b1; seed_in = 16'($urandom); end
         if (cyc == pd_at) process_done = 1'b1;
         tick();
         start = 1'b0;
         seed_in = seed;
         cyc++;
         if (cyc == pd_at + 1) begin
            n_cmp++;
            if (busy !== 1'b1 || n_done != 0) begin
               n_err++;
               $display("FAIL %s stray_done: busy %b dones %0d want busy 1 dones 0", name, busy, n_done);
            end
         end
      end
      n_cmp++;
      if (n_done == 0) begin n_err++; $display("FAIL %s timeout: no sample_done in %0d cycles", name, cyc); end
      n_cmp++;
      if (got_ev.size() != exp_ev.size()) begin
         n_err++;
         $display("FAIL %s event_count_at_done: got %0d events want %0d", name, got_ev.size(), exp_ev.size());
      end
      repeat (3) tick();
      n_cmp++;
      if (n_done != 1) begin n_err++; $display("FAIL %s done_pulses: got %0d want 1", name, n_done); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after_done: got %b want 0", name, busy); end
      n_cmp++;
      if (ev_cnt !== exp_cnt) begin n_err++; $display("FAIL %s event_cnt: got %0d want %0d", name, ev_cnt, exp_cnt); end
      for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
         n_cmp++;
         if (got_ev[i] !== exp_ev[i]) begin
            n_err++;
            $display("FAIL %s event[%0d]: got %h want %h", name, i, got_ev[i], exp_ev[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp += 7;
      if (req !== 1'b0)       begin n_err++; $display("FAIL rst_req: got %b want 0", req); end
      if (aer_addr !== 12'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", aer_addr); end
      if (pix_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", pix_rd_en); end
      if (pix_addr !== 10'h0) begin n_err++; $display("FAIL rst_pix_addr: got %h want 0", pix_addr); end
      if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (sdone !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %b want 0", sdone); end
      if (ev_cnt !== 16'h0)   begin n_err++; $display("FAIL rst_event_cnt: got %h want 0", ev_cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_zero_pixels();
      reset_dut();
      for (int p = 0; p < NN; p++) mem[p] = 8'd0;
      run_sample(16'($urandom), 0, -1, -1, "zero_pixels");
   endtask

   task automatic test_full_pixels();
      reset_dut();
      for (int p = 0; p < NN; p++) mem[p] = 8'd255;
      run_sample(16'h0001, 0, -1, -1, "full_pixels");
   endtask

   task automatic test_equal_boundary();
      logic [15:0] s, l;
      reset_dut();
      s = 16'($urandom) | 16'h1;
      l = s;
      for (int p = 0; p < NN; p++) begin
         mem[p] = l[7:0];
         l = lfsr_step(l);
      end
      run_sample(s, 1, -1, -1, "equal_boundary");
   endtask

   task automatic test_ack_stall();
      reset_dut();
      for (int p = 0; p < NN; p++) mem[p] = 8'd255;
      run_sample(16'hBEEF, 10, -1, -1, "ack_stall");
      n_cmp++;
      if (max_run < 10) begin n_err++; $display("FAIL ack_stall_hold: req held %0d cycles want >= 10", max_run); end
   endtask

   task automatic test_restart_seed0();
      reset_dut();
      for (int p = 0; p < NN; p++) mem[p] = 8'($urandom);
      run_sample(16'h0000, 1, 15, -1, "restart_seed0");
      run_sample(16'hACE1, 1, -1, -1, "seed_ace1");
   endtask

   task automatic test_reset_mid();
      int cyc;
      reset_dut();
      for (int p = 0; p < NN; p++) mem[p] = 8'd255;
      got_ev.delete();
      markers = 0;
      ack_lat = 5;
      seed_in = 16'h1234;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!(req && ev_cnt != 16'h0) && cyc < 2000) begin tick(); cyc++; end
      n_cmp++;
      if (cyc >= 2000) begin n_err++; $display("FAIL reset_mid_reach: no handshake with events after %0d cycles", cyc); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ack = 1'b0;
      wait_cnt = 0;
      n_cmp += 3;
      if (req !== 1'b0)     begin n_err++; $display("FAIL reset_mid_req: got %b want 0", req); end
      if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
      if (ev_cnt !== 16'h0) begin n_err++; $display("FAIL reset_mid_cnt: got %0d want 0", ev_cnt); end
      repeat (3) tick();
      n_cmp++;
      if (busy !== 1'b0 || pix_rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_idle: busy %b rd_en %b want 0 0", busy, pix_rd_en);
      end
      run_sample(16'h1234, 0, -1, -1, "after_reset");
   endtask

   task automatic test_stray_done();
      reset_dut();
      for (int p = 0; p < NN; p++) mem[p] = 8'($urandom);
      run_sample(16'($urandom), 0, -1, 3, "stray_done");
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         for (int p = 0; p < NN; p++) mem[p] = 8'($urandom);
         run_sample(16'($urandom), int'($urandom_range(0, 3)), -1, -1, "random");
      end
   endtask

   initial begin
      for (int p = 0; p < NN; p++) mem[p] = 8'd0;
      test_reset();
      test_zero_pixels();
      test_full_pixels();
      test_equal_boundary();
      test_ack_stall();
      test_restart_seed0();
      test_reset_mid();
      test_stray_done();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
